// File: rtl/multu_hilo_pkg.sv
// Shared function codes and multiplier FSM state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package multu_hilo_pkg;

    // Function codes shared by the ALU, shifter, HI/LO mux and multiplier.
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/multu_hilo_hilo_reg.sv
// HI/LO register pair with write enable; outputs are the stored halves.
// Latency: 1 clock from wr_en to visible outputs.
// Backpressure: none; a write is taken on every enabled edge.
// Ports: clk, reset (sync active-low), wr_en, hi_next/lo_next in, hi/lo out.
module hilo_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] hi_next,
    input  logic [WIDTH-1:0] lo_next,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (wr_en) begin
            hi <= hi_next;
            lo <= lo_next;
        end
    end

endmodule

// File: rtl/multu_hilo.sv
// Sequential unsigned multiplier (one shift-add step per clock) owning HI/LO.
// Latency: 33 clocks from the start edge to HI/LO update; done pulses in DONE.
// Backpressure: none; starts arriving while busy are dropped, issuer stalls on busy.
// Ports: clk, reset (sync active-low), dataA/dataB operands, Signal function code,
//        HiOut/LoOut product halves, busy, done.
module multu_hilo
    import multu_hilo_pkg::*;
#(
    parameter int         WIDTH      = 32,
    parameter logic [5:0] MULTU_CODE = FN_MULTU
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int PW    = 2 * WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mult_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mcand;
    logic [PW-1:0]    prod;
    logic [WIDTH:0]   upper_sum;

    // Upper half plus multiplicand when the current multiplier bit is set;
    // the extra bit keeps the carry so the shift brings it back into range.
    always_comb begin
        upper_sum = prod[PW-1:WIDTH];
        if (prod[0]) begin
            upper_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            mcand <= '0;
            prod  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Signal == MULTU_CODE) begin
                        state <= RUN;
                        mcand <= dataA;
                        prod  <= {{(WIDTH + 1){1'b0}}, dataB};
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    prod <= {1'b0, upper_sum, prod[WIDTH-1:1]};
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // prod holds the fully shifted product for the whole DONE cycle.
    hilo_reg #(
        .WIDTH(WIDTH)
    ) u_hilo_reg (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (state == DONE),
        .hi_next (prod[2*WIDTH-1:WIDTH]),
        .lo_next (prod[WIDTH-1:0]),
        .hi      (HiOut),
        .lo      (LoOut)
    );

endmodule
